// File: rtl/eeprom_rd_ctrl.sv
// I2C master that random-reads NBYTES consecutive bytes from a 24C02-class EEPROM.
// Optional power-up auto-load is enabled by defining AUTO_LOAD_EN.
module eeprom_rd_ctrl #(
  parameter int         SYS_CLK_HZ = 50_000_000,
  parameter int         I2C_HZ     = 100_000,
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter logic [7:0] WORD_ADDR  = 8'h00,
  parameter int         NBYTES     = 2,
  parameter int         PWRUP_CYC  = 250_000
) (
  input  logic                  sclk,
  input  logic                  rst,
  input  logic                  rd_start,
  output logic                  rd_busy,
  output logic                  rd_done,
  output logic                  rd_err,
  output logic [8*NBYTES-1:0]   rd_data,
  output logic                  i2c_scl,
  output logic                  i2c_sda_oe,
  input  logic                  i2c_sda_i,
  output logic [3:0]            state_dbg
);

  localparam int DIV = SYS_CLK_HZ / (4 * I2C_HZ);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW  = $clog2(NBYTES + 1);

  typedef enum logic [3:0] {
    IDLE, START, TX_DEVW, ACK_A, TX_WORD, ACK_B, RSTART,
    TX_DEVR, ACK_C, RX_BYTE, MACK, STOP, DONE
  } state_t;

  state_t              state, state_nx;
  logic [TW-1:0]       tick;
  logic [1:0]          phase;
  logic [2:0]          bit_cnt;
  logic [BW-1:0]       byte_cnt;
  logic [7:0]          rx_sh;
  logic [8*NBYTES-1:0] shadow;
  logic                nack;
  logic                start_req;
  logic                tick_last, bit_end, sample_pt;
  logic                scl_c, oe_c;
  logic [7:0]          tx_byte;

  // Handshake: rd_start is a one-cycle request honoured only in IDLE; rd_busy
  // covers START..STOP, and rd_done (with rd_err) pulses once in DONE.
`ifdef AUTO_LOAD_EN
  localparam int PW = $clog2(PWRUP_CYC + 1);
  logic [PW-1:0] pwr_cnt;
  logic          pwr_fired;

  always_ff @(posedge sclk) begin
    if (rst) begin
      pwr_cnt   <= '0;
      pwr_fired <= 1'b0;
    end else if (!pwr_fired) begin
      if (pwr_cnt == PW'(PWRUP_CYC - 1)) pwr_fired <= 1'b1;
      else                               pwr_cnt   <= pwr_cnt + 1'b1;
    end
  end

  assign start_req = pwr_fired ? rd_start : (pwr_cnt == PW'(PWRUP_CYC - 1));
`else
  logic [31:0] unused_pwrup;
  assign unused_pwrup = 32'(PWRUP_CYC);
  assign start_req    = rd_start;
`endif

  assign tick_last = (tick == TW'(DIV - 1));
  assign sample_pt = tick_last && (phase == 2'd2);
  assign bit_end   = tick_last && (phase == 2'd3);
  assign rd_busy   = (state != IDLE) && (state != DONE);
  assign rd_done   = (state == DONE);
  assign rd_err    = nack;
  assign state_dbg = state;

  always_ff @(posedge sclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    scl_c    = 1'b1;
    oe_c     = 1'b0;
    tx_byte  = {DEV_ADDR, 1'b0};
    case (state)
      IDLE: if (start_req) state_nx = START;
      START: begin
        scl_c = (phase != 2'd3);
        oe_c  = phase[1];
        if (bit_end) state_nx = TX_DEVW;
      end
      TX_DEVW, TX_WORD, TX_DEVR: begin
        if (state == TX_WORD) tx_byte = WORD_ADDR;
        if (state == TX_DEVR) tx_byte = {DEV_ADDR, 1'b1};
        scl_c = (phase == 2'd1) || (phase == 2'd2);
        oe_c  = !tx_byte[3'd7 - bit_cnt];
        if (bit_end && bit_cnt == 3'd7)
          state_nx = (state == TX_DEVW) ? ACK_A : (state == TX_WORD) ? ACK_B : ACK_C;
      end
      ACK_A, ACK_B, ACK_C: begin
        scl_c = (phase == 2'd1) || (phase == 2'd2);
        if (bit_end) begin
          if (nack)                state_nx = STOP;
          else if (state == ACK_A) state_nx = TX_WORD;
          else if (state == ACK_B) state_nx = RSTART;
          else                     state_nx = RX_BYTE;
        end
      end
      // Repeated start: release SDA while SCL is low, then pull it low under high SCL.
      RSTART: begin
        scl_c = (phase == 2'd1) || (phase == 2'd2);
        oe_c  = phase[1];
        if (bit_end) state_nx = TX_DEVR;
      end
      RX_BYTE: begin
        scl_c = (phase == 2'd1) || (phase == 2'd2);
        if (bit_end && bit_cnt == 3'd7) state_nx = MACK;
      end
      MACK: begin
        scl_c = (phase == 2'd1) || (phase == 2'd2);
        oe_c  = (byte_cnt != BW'(NBYTES - 1));
        if (bit_end) state_nx = (byte_cnt == BW'(NBYTES - 1)) ? STOP : RX_BYTE;
      end
      STOP: begin
        scl_c = (phase != 2'd0);
        oe_c  = !phase[1];
        if (bit_end) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Pin outputs are registered so SCL/SDA never glitch on state decode.
  always_ff @(posedge sclk) begin
    if (rst) begin
      tick       <= '0;
      phase      <= 2'd0;
      bit_cnt    <= 3'd0;
      byte_cnt   <= '0;
      rx_sh      <= 8'h00;
      shadow     <= '0;
      nack       <= 1'b0;
      rd_data    <= '0;
      i2c_scl    <= 1'b1;
      i2c_sda_oe <= 1'b0;
    end else begin
      i2c_scl    <= scl_c;
      i2c_sda_oe <= oe_c;
      if (state == IDLE || state == DONE) begin
        tick    <= '0;
        phase   <= 2'd0;
        bit_cnt <= 3'd0;
      end else begin
        tick <= tick_last ? '0 : tick + 1'b1;
        if (tick_last) phase <= phase + 1'b1;
        if (bit_end)   bit_cnt <= (state_nx == state) ? bit_cnt + 1'b1 : 3'd0;
      end
      if (state == IDLE && start_req) begin
        nack     <= 1'b0;
        byte_cnt <= '0;
      end
      if (sample_pt && (state == ACK_A || state == ACK_B || state == ACK_C) && i2c_sda_i)
        nack <= 1'b1;
      if (sample_pt && state == RX_BYTE) rx_sh <= {rx_sh[6:0], i2c_sda_i};
      if (bit_end && state == RX_BYTE && bit_cnt == 3'd7)
        shadow[{byte_cnt, 3'b000} +: 8] <= rx_sh;
      if (bit_end && state == MACK) byte_cnt <= byte_cnt + 1'b1;
      if (state == DONE && !nack) rd_data <= shadow;
    end
  end

endmodule

// File: tb/tb_eeprom_rd_ctrl.sv
// Bench for eeprom_rd_ctrl: behavioural 24C02 slave on the bus, vector table,
// randomized transactions against a reference model, and reset/auto-load corners.
module tb_eeprom_rd_ctrl;
  localparam int NB = 2;

  logic           sclk = 1'b0;
  logic           rst = 1'b1;
  logic           rd_start = 1'b0;
  logic           rd_busy, rd_done, rd_err;
  logic [8*NB-1:0] rd_data;
  logic           i2c_scl, i2c_sda_oe, i2c_sda_i;
  logic [3:0]     state_dbg;
  logic           slave_pull = 1'b0;

  assign i2c_sda_i = !(i2c_sda_oe || slave_pull);

  eeprom_rd_ctrl #(
    .SYS_CLK_HZ(1_600_000), .I2C_HZ(100_000), .DEV_ADDR(7'h50),
    .WORD_ADDR(8'h00), .NBYTES(NB), .PWRUP_CYC(100)
  ) dut (
    .sclk(sclk), .rst(rst), .rd_start(rd_start), .rd_busy(rd_busy),
    .rd_done(rd_done), .rd_err(rd_err), .rd_data(rd_data), .i2c_scl(i2c_scl),
    .i2c_sda_oe(i2c_sda_oe), .i2c_sda_i(i2c_sda_i), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 sclk = ~sclk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- EEPROM slave model ----------------
  // Bus events: 0..255 byte written by master, 256 START, 257 STOP,
  // 300 master ACK after a read byte, 301 master NACK.
  logic [7:0] mem [256];
  int         sst = 0;          // 0 ignore, 1 addr, 2 word, 3 send data, 4 write data
  int         bitc = 0;         // SCL rises seen in the current byte slot
  logic [7:0] sh = 8'h00;
  logic [7:0] tx = 8'h00;
  logic [7:0] ptr = 8'h00;
  logic       rd_dir = 1'b0;
  logic       last_ack = 1'b0;
  logic       m_nack = 1'b0;
  int         nack_sel = 0;     // 1 NACK write address, 2 NACK read address
  int         bus_log[$];
  int         exp_bus[$];
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  int         proto_err = 0;
  int         done_cnt = 0;

  always @(negedge sclk) begin
    logic scl_s, sda_s;
    scl_s = i2c_scl;
    sda_s = i2c_sda_i;
    if (rd_done === 1'b1) done_cnt++;
    if (prev_scl !== scl_s && prev_sda !== sda_s) proto_err++;
    else if (prev_scl && scl_s && prev_sda && !sda_s) begin
      bus_log.push_back(256); sst = 1; bitc = 0; slave_pull = 1'b0;
    end else if (prev_scl && scl_s && !prev_sda && sda_s) begin
      bus_log.push_back(257); sst = 0; bitc = 0; slave_pull = 1'b0;
    end else if (!prev_scl && scl_s && sst != 0) begin
      if (bitc < 8) sh = {sh[6:0], sda_s};
      else if (sst == 3) begin m_nack = sda_s; bus_log.push_back(sda_s ? 301 : 300); end
      bitc++;
    end else if (prev_scl && !scl_s && sst != 0) begin
      if (bitc == 8) begin
        if (sst == 3) slave_pull = 1'b0;
        else begin
          bus_log.push_back(int'(sh));
          if (sst == 1) begin
            rd_dir   = sh[0];
            last_ack = (sh[7:1] == 7'h50) && !(nack_sel == 1 && !sh[0]) && !(nack_sel == 2 && sh[0]);
          end else begin
            if (sst == 2) ptr = sh;
            last_ack = 1'b1;
          end
          slave_pull = last_ack;
        end
      end else if (bitc == 9) begin
        bitc = 0;
        slave_pull = 1'b0;
        if (sst == 1) sst = !last_ack ? 0 : (rd_dir ? 3 : 2);
        else if (sst == 2) sst = 4;
        else if (sst == 3 && m_nack) sst = 0;
        if (sst == 3) begin tx = mem[ptr]; ptr = ptr + 8'd1; slave_pull = !tx[7]; end
      end else if (bitc >= 1 && bitc <= 7 && sst == 3) begin
        slave_pull = !tx[7 - bitc];
      end
    end
    prev_scl = scl_s;
    prev_sda = !(i2c_sda_oe || slave_pull);
  end

  // ---------------- reference model / scoreboard ----------------
  logic [8*NB-1:0] exp_q[$];
  logic [8*NB-1:0] model_data = '0;

  task automatic build_exp_bus(input int ns);
    exp_bus.delete();
    exp_bus.push_back(256); exp_bus.push_back(8'hA0);
    if (ns == 1) begin exp_bus.push_back(257); return; end
    exp_bus.push_back(8'h00); exp_bus.push_back(256); exp_bus.push_back(8'hA1);
    if (ns == 2) begin exp_bus.push_back(257); return; end
    for (int k = 0; k < NB; k++) exp_bus.push_back(k == NB - 1 ? 301 : 300);
    exp_bus.push_back(257);
  endtask

  function automatic logic [8*NB-1:0] model_read(input int ns);
    logic [8*NB-1:0] d;
    if (ns != 0) return model_data;
    for (int k = 0; k < NB; k++) d[8*k +: 8] = mem[8'(k)];
    return d;
  endfunction

  // ---------------- driver ----------------
  // Entered and left at #1 after a rising edge.
  task automatic run_txn(input logic [7:0] b0, input logic [7:0] b1, input int ns,
                         input int extra, input bit at_done, input logic exp_err,
                         input logic [8*NB-1:0] exp_data);
    int n, d0, bad;
    mem[8'h00] = b0; mem[8'h01] = b1; nack_sel = ns;
    bus_log.delete();
    d0 = done_cnt;
    exp_q.push_back(exp_data);
    rd_start = 1'b1;
    @(posedge sclk); #1 rd_start = 1'b0;
    check("busy_rise", rd_busy, 1);
    for (int i = 0; i < extra; i++) begin
      repeat ($urandom_range(5, 40)) @(posedge sclk);
      #1 rd_start = 1'b1;
      @(posedge sclk); #1 rd_start = 1'b0;
    end
    n = 0;
    while (rd_done !== 1'b1 && n < 5000) begin @(posedge sclk); #1; n++; end
    check("done_seen", rd_done, 1);
    check("busy_at_done", rd_busy, 0);
    check("rd_err", rd_err, exp_err);
    if (at_done) rd_start = 1'b1;
    @(posedge sclk); #1 rd_start = 1'b0;
    check("rd_data", rd_data, exp_q.pop_front());
    repeat (150) @(posedge sclk);
    #1;
    check("busy_idle", rd_busy, 0);
    check("done_pulses", done_cnt - d0, 1);
    build_exp_bus(ns);
    check("bus_len", bus_log.size(), exp_bus.size());
    bad = -1;
    for (int i = 0; i < bus_log.size() && i < exp_bus.size(); i++)
      if (bus_log[i] != exp_bus[i] && bad < 0) bad = i;
    check("bus_seq_first_bad", bad, -1);
    model_data = exp_data;
  endtask

  typedef struct {
    logic [7:0]      b0, b1;
    int              ns, extra;
    bit              at_done;
    logic            exp_err;
    logic [8*NB-1:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #5_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int n, d0;
    vecs[0] = '{8'h34, 8'h12, 0, 0, 1'b0, 1'b0, 16'h1234};
    vecs[1] = '{8'h56, 8'h78, 1, 0, 1'b0, 1'b1, 16'h1234};
    vecs[2] = '{8'h9A, 8'hBC, 0, 3, 1'b0, 1'b0, 16'hBC9A};
    vecs[3] = '{8'hFF, 8'h00, 2, 0, 1'b1, 1'b1, 16'hBC9A};
    vecs[4] = '{8'h00, 8'hFF, 0, 0, 1'b1, 1'b0, 16'hFF00};
    vecs[5] = '{8'hA5, 8'h5A, 1, 2, 1'b0, 1'b1, 16'hFF00};
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h34; mem[8'h01] = 8'h12;

    rst = 1'b1;
    repeat (3) @(posedge sclk);
    #1;
    check("rst_busy", rd_busy, 0);
    check("rst_done", rd_done, 0);
    check("rst_err", rd_err, 0);
    check("rst_data", rd_data, 0);
    check("rst_scl", i2c_scl, 1);
    check("rst_sda_oe", i2c_sda_oe, 0);
    rst = 1'b0;

`ifdef AUTO_LOAD_EN
    // Auto-load: busy must rise exactly 100 cycles after reset release; rd_start is ignored meanwhile.
    n = 0;
    while (rd_busy !== 1'b1 && n < 1000) begin
      rd_start = (n == 50);
      @(posedge sclk); #1;
      n++;
    end
    rd_start = 1'b0;
    check("auto_start_cycle", n, 100);
    n = 0;
    while (rd_done !== 1'b1 && n < 5000) begin @(posedge sclk); #1; n++; end
    check("auto_done_seen", rd_done, 1);
    @(posedge sclk); #1;
    check("auto_rd_data", rd_data, 16'h1234);
    model_data = 16'h1234;
`endif

    repeat (5) @(posedge sclk);
    #1;
    for (int i = 0; i < 6; i++)
      run_txn(vecs[i].b0, vecs[i].b1, vecs[i].ns, vecs[i].extra, vecs[i].at_done,
              vecs[i].exp_err, vecs[i].exp_data);

    for (int i = 0; i < 6; i++) begin
      logic [7:0] r0, r1;
      int ns;
      r0 = 8'($urandom_range(0, 255));
      r1 = 8'($urandom_range(0, 255));
      ns = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 2)) : 0;
      mem[8'h00] = r0; mem[8'h01] = r1; nack_sel = ns;
      run_txn(r0, r1, ns, int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)),
              logic'(ns != 0), model_read(ns));
    end
    check("exp_q_empty", exp_q.size(), 0);
    check("sda_vs_scl_edges", proto_err, 0);

    // Reset in the middle of the first received byte, during bit 3.
    mem[8'h00] = 8'h34; mem[8'h01] = 8'h12; nack_sel = 0;
    rst = 1'b1;
    @(posedge sclk); #1 rst = 1'b0;
    rd_start = 1'b1;
    @(posedge sclk); #1 rd_start = 1'b0;
    n = 0;
    while (!(sst == 3 && bitc == 3 && i2c_scl == 1'b0) && n < 5000) begin @(negedge sclk); n++; end
    check("reached_rx_bit3", (sst == 3 && bitc == 3), 1);
    d0 = done_cnt;
    rst = 1'b1;
    @(posedge sclk); #1;
    rst = 1'b0;
    check("midrst_scl", i2c_scl, 1);
    check("midrst_sda_oe", i2c_sda_oe, 0);
    check("midrst_busy", rd_busy, 0);
    check("midrst_data", rd_data, 0);
    sst = 0; bitc = 0; slave_pull = 1'b0;
    repeat (90) @(posedge sclk);
    #1;
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_data_hold", rd_data, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
